serial_nibble_adder: RTL and testbench

- Multi-cycle wide adder that consumes the 4-bit adder stage. Adds two NIBBLES×4-bit operands one nibble per clock, least-significant nibble first.
- Instantiates `adder_4bit` twice, in cascade:
  - first instance: operand nibbles;
  - second instance: injects the stored inter-nibble carry.
- Sits downstream of the 4-bit adder and lets it serve wider datapaths without a wider combinational adder.
- Start/busy/done handshake toward the controlling logic.

---
 rtl/serial_nibble_adder.sv | 139 +++++++++++++
 tb/tb_serial_nibble_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_adder.sv
// ============================================================================
// Module   : serial_nibble_adder (with adder_4bit slice)
// Brief    : Wide adder that sums one 4-bit slice per clock, LSB nibble first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

module serial_nibble_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_s1;
    logic [3:0]      w_s2;
    logic            w_c1;
    logic            w_c2;

    assign w_a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign w_b_nib = b_q[{idx_q, 2'b00} +: 4];

    // Operand slice first, then the stored inter-nibble carry is injected.
    adder_4bit u_add_ops (
        .a_i    (w_a_nib),
        .b_i    (w_b_nib),
        .sum_o  (w_s1),
        .cout_o (w_c1)
    );

    adder_4bit u_add_carry (
        .a_i    (w_s1),
        .b_i    ({3'b000, carry_q}),
        .sum_o  (w_s2),
        .cout_o (w_c2)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                res_d[{idx_q, 2'b00} +: 4] = w_s2;
                carry_d = w_c1 | w_c2;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = w_c1 | w_c2;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = (state_q == ADD);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign carry_out = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_adder.sv
// ============================================================================
// Module   : tb_serial_nibble_adder
// Brief    : Self-checking bench; arithmetic reference model plus literal pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_nibble_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start4 = 1'b0;
    logic [W-1:0] a4 = '0;
    logic [W-1:0] b4 = '0;
    logic         busy4, done4, cout4;
    logic [W-1:0] res4;

    logic         start1 = 1'b0;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         busy1, done1, cout1;
    logic [3:0]   res1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_nibble_adder #(.NIBBLES(N)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(a4), .op_b(b4),
        .busy(busy4), .done(done4), .result(res4), .carry_out(cout4)
    );

    serial_nibble_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1),
        .busy(busy1), .done(done1), .result(res1), .carry_out(cout1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: full-width sum computed once; k completed slices expose sum mod 2^(4k).
    bit           m_act = 1'b0;
    bit           m_done = 1'b0;
    int           m_k = 0;
    logic [W:0]   m_sum = '0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        logic [W:0] msk;
        if (rst) begin
            m_act = 1'b0; m_done = 1'b0; m_k = 0; m_res = '0; m_cout = 1'b0;
        end else if (!m_act && start4) begin
            m_sum  = {1'b0, a4} + {1'b0, b4};
            m_act  = 1'b1; m_done = 1'b0; m_k = 0; m_res = '0; m_cout = 1'b0;
        end else if (m_act) begin
            m_k++;
            msk   = ((W+1)'(1) << (4 * m_k)) - 1'b1;
            m_res = m_sum[W-1:0] & msk[W-1:0];
            if (m_k == N) begin
                m_act  = 1'b0;
                m_done = 1'b1;
                m_cout = m_sum[W];
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy4), 64'(m_act));
            chk("done", 64'(done4), 64'(m_done));
            chk("result", 64'(res4), 64'(m_res));
            chk("carry_out", 64'(cout4), 64'(m_cout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count cycles until done (start edge = cycle 0 end).
    task automatic run4(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
        a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset busy", 64'(busy4), 64'd0);
        chk("reset result", 64'(res4), 64'd0);

        // 1: alternating patterns
        run4(16'h5A5A, 16'hA5A5, cyc);
        chk("t1 done cycle", 64'(cyc), 64'd5);
        chk("t1 result", 64'(res4), 64'hFFFF);
        chk("t1 carry", 64'(cout4), 64'd0);
        tick();

        // 2: full ripple
        run4(16'hFFFF, 16'h0001, cyc);
        chk("t2 result", 64'(res4), 64'h0000);
        chk("t2 carry", 64'(cout4), 64'd1);
        tick();

        // 3: operand change and stray start while busy
        a4 = 16'h0B00; b4 = 16'h0F00; start4 = 1'b1;
        tick();                       // cycle 1
        start4 = 1'b0;
        tick();                       // cycle 2
        a4 = 16'hFFFF;
        tick();                       // cycle 3
        start4 = 1'b1;
        tick();                       // cycle 4
        start4 = 1'b0;
        chk("t3 not done early", 64'(done4), 64'd0);
        tick();                       // cycle 5
        chk("t3 done", 64'(done4), 64'd1);
        chk("t3 result", 64'(res4), 64'h1A00);
        chk("t3 carry", 64'(cout4), 64'd0);
        tick();

        // 4: back-to-back start on the done cycle
        run4(16'h0005, 16'h000A, cyc);
        chk("t4a done cycle", 64'(cyc), 64'd5);
        chk("t4a result", 64'(res4), 64'h000F);
        chk("t4a carry", 64'(cout4), 64'd0);
        a4 = 16'h8000; b4 = 16'h8000; start4 = 1'b1;
        tick();                       // cycle 6
        start4 = 1'b0;
        chk("t4b busy c6", 64'(busy4), 64'd1);
        cyc = 6;
        while (!done4 && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t4b done cycle", 64'(cyc), 64'd10);
        chk("t4b result", 64'(res4), 64'h0000);
        chk("t4b carry", 64'(cout4), 64'd1);
        tick();

        // 5: reset mid-operation
        a4 = 16'h1234; b4 = 16'h1111; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();                       // cycle 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 busy", 64'(busy4), 64'd0);
        chk("t5 done", 64'(done4), 64'd0);
        chk("t5 result", 64'(res4), 64'd0);
        chk("t5 carry", 64'(cout4), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5 no done", 64'(done4), 64'd0);
        end
        run4(16'h0001, 16'h0001, cyc);
        chk("t5 new result", 64'(res4), 64'h0002);
        tick();

        // 6: single-nibble instance
        a1 = 4'b1011; b1 = 4'b1111; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t6 busy c1", 64'(busy1), 64'd1);
        chk("t6 done c1", 64'(done1), 64'd0);
        tick();
        chk("t6 busy c2", 64'(busy1), 64'd0);
        chk("t6 done c2", 64'(done1), 64'd1);
        chk("t6 result", 64'(res1), 64'hA);
        chk("t6 carry", 64'(cout1), 64'd1);
        a1 = 4'b0000; b1 = 4'b1101; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        chk("t6b done", 64'(done1), 64'd1);
        chk("t6b result", 64'(res1), 64'hD);
        chk("t6b carry", 64'(cout1), 64'd0);

        // Random traffic: operands churn every cycle, start and rare resets at random.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: a4 = '1;
                default: a4 = W'($urandom);
            endcase
            b4 = ($urandom_range(0, 4) == 0) ? W'(1) : W'($urandom);
            start4 = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 40) == 0);
            tick();
        end
        rst = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
